// File: rtl/cpu_clk_pkg.sv
// Shared constants for the CPU clock generator: mode codes, FSM encodings, default widths.
package cpu_clk_pkg;

  localparam int DEF_CNT_W = 32;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_HALT = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_FREE = 2'd0;
  localparam state_t ST_HOLD = 2'd1;
  localparam state_t ST_STEP = 2'd2;

  function automatic logic is_run(input logic [1:0] m);
    return m == MODE_RUN;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: counter 0..div-1, toggles div_clk on wrap, tick on rising toggle.
module clk_div_ch
  import cpu_clk_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] div,
  output logic             div_clk,
  output logic             tick,
  output logic             fall_nxt
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic             wrap;

  // A divisor of 0 wraps every cycle, same as 1.
  assign last     = (div == '0) ? '0 : div - CNT_W'(1);
  assign wrap     = (cnt == last);
  // Next enabled edge takes div_clk 1->0; lets the step FSM end on that same edge.
  assign fall_nxt = en & ~restart & wrap & div_clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (restart) begin
      cnt     <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt     <= '0;
        div_clk <= ~div_clk;
        tick    <= ~div_clk;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/cpu_clk_gen.sv
// Multi-channel clock generator with run/halt/step control and runtime divisor reload.
// Define CLKGEN_STEP_EN to build the single-step state and step_req synchroniser.
module cpu_clk_gen
  import cpu_clk_pkg::*;
#(
  parameter int NCH     = 5,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int DEF_DIV = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic                 step_req,
  input  logic                 cfg_load,
  input  logic [NCH*CNT_W-1:0] div_cfg,
  output logic [NCH-1:0]       div_clk,
  output logic [NCH-1:0]       tick,
  output logic                 busy,
  output logic                 run_led
);

  logic [1:0]                 mode_s1, mode_s2;
  logic [1:0]                 vld_pipe;
  logic [NCH-1:0][CNT_W-1:0]  div_q;
  state_t                     state, state_nxt;
  logic                       en;
  logic [NCH-1:0]             fall_nxt;
  logic                       unused_fall;

  assign unused_fall = ^fall_nxt;

  // vld_pipe keeps the FSM from acting on the reset value of the mode synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_s1  <= 2'b00;
      mode_s2  <= 2'b00;
      vld_pipe <= 2'b00;
    end else begin
      mode_s1  <= mode;
      mode_s2  <= mode_s1;
      vld_pipe <= {vld_pipe[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          div_q <= {NCH{CNT_W'(DEF_DIV)}};
    else if (cfg_load) div_q <= div_cfg;
  end

`ifdef CLKGEN_STEP_EN
  logic [2:0] step_s;
  logic       step_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_s <= 3'b000;
    else      step_s <= {step_s[1:0], step_req};
  end

  assign step_rise = step_s[1] & ~step_s[2];
`else
  logic unused_step;
  assign unused_step = step_req;
`endif

  always_comb begin
    state_nxt = state;
    if (vld_pipe[1]) begin
      if (is_run(mode_s2)) begin
        state_nxt = ST_FREE;
      end else begin
        case (state)
          ST_FREE: state_nxt = ST_HOLD;
`ifdef CLKGEN_STEP_EN
          ST_HOLD: if (step_rise && mode_s2 == MODE_STEP && !cfg_load) state_nxt = ST_STEP;
          ST_STEP: if (cfg_load || mode_s2 != MODE_STEP || fall_nxt[0]) state_nxt = ST_HOLD;
`endif
          default: state_nxt = ST_HOLD;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_HOLD;
      run_led <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_led <= (state_nxt == ST_FREE);
    end
  end

`ifdef CLKGEN_STEP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= 1'b0;
    else      busy <= (state_nxt == ST_STEP);
  end
`else
  assign busy = 1'b0;
`endif

  assign en = (state == ST_FREE) || (state == ST_STEP);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .restart  (cfg_load),
      .div      (div_q[i]),
      .div_clk  (div_clk[i]),
      .tick     (tick[i]),
      .fall_nxt (fall_nxt[i])
    );
  end

endmodule
